// File: rtl/gpio_pio_pkg.sv
// Shared definitions for the gpio_pio_irq peripheral: register map and edge polarity.
package gpio_pio_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_MASK     = 3'd2;
  localparam logic [2:0] REG_CAP      = 3'd3;
  localparam logic [2:0] REG_EDGE_SEL = 3'd4;
  localparam logic [2:0] REG_DB_LIMIT = 3'd5;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input: synchroniser, debounce counter and stable flop.
// changed pulses on the edge where stable takes the new value.
module gpio_debounce_bit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            din,
  input  logic [DB_W-1:0] limit,
  input  logic            clr,
  input  logic            prime,
  output logic            stable,
  output logic            changed
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DB_W-1:0]        cnt_q, cnt_d, cnt_inc, eff_limit;
  logic                   stable_q, stable_d;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  always_comb begin
    eff_limit = (limit == '0) ? DB_W'(1) : limit;
    cnt_inc   = cnt_q + DB_W'(1);
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed   = 1'b0;
    if (prime) begin
      stable_d = sync;
      cnt_d    = '0;
    end else if (clr || (sync == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_inc >= eff_limit) begin
      stable_d = sync;
      cnt_d    = '0;
      changed  = 1'b1;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/gpio_pio_irq.sv
// Avalon-MM GPIO with per-bit direction, debounced inputs, edge capture and level irq.
module gpio_pio_irq
  import gpio_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 16,
  parameter int unsigned DB_DEFAULT  = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe
);

  localparam logic [2:0] PRIME_LEN = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_q, data_d, dir_q, dir_d, mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d, edge_q, edge_d, cap_set, cap_clr;
  logic [DB_W-1:0]  limit_q, limit_d;
  logic [31:0]      readdata_q, readdata_d, rdata;
  logic             irq_q, irq_d;
  logic [2:0]       prime_cnt_q;
  logic             prime, wr_en, rd_en, db_clr;
  logic [WIDTH-1:0] stable, changed;
  logic             wd_unused;

  assign wd_unused = ^writedata;
  assign prime     = (prime_cnt_q != PRIME_LEN);
  assign wr_en     = chipselect && write;
  assign rd_en     = chipselect && read;
  assign db_clr    = wr_en && (address == REG_DB_LIMIT);

  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    gpio_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_W       (DB_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .din    (pio_in[g]),
      .limit  (limit_q),
      .clr    (db_clr),
      .prime  (prime),
      .stable (stable[g]),
      .changed(changed[g])
    );
  end

  always_comb begin
    data_d  = data_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    edge_d  = edge_q;
    limit_d = limit_q;
    cap_clr = '0;
    if (wr_en) begin
      case (address)
        REG_DATA:     data_d  = writedata[WIDTH-1:0];
        REG_DIR:      dir_d   = writedata[WIDTH-1:0];
        REG_MASK:     mask_d  = writedata[WIDTH-1:0];
        REG_CAP:      cap_clr = writedata[WIDTH-1:0];
        REG_EDGE_SEL: edge_d  = writedata[WIDTH-1:0];
        REG_DB_LIMIT: limit_d = writedata[DB_W-1:0];
        default: ;
      endcase
    end

    // changed fires on the edge stable flips, so the old stable value gives the direction
    cap_set = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cap_set[i] = changed[i] && !dir_q[i] &&
                   ((edge_sel_e'(edge_q[i]) == EDGE_FALL) ? stable[i] : !stable[i]);
    end
    cap_d = (cap_q & ~cap_clr) | cap_set;
    irq_d = |(cap_q & mask_q);

    rdata = '0;
    case (address)
      REG_DATA:     rdata[WIDTH-1:0] = (stable & ~dir_q) | (data_q & dir_q);
      REG_DIR:      rdata[WIDTH-1:0] = dir_q;
      REG_MASK:     rdata[WIDTH-1:0] = mask_q;
      REG_CAP:      rdata[WIDTH-1:0] = cap_q;
      REG_EDGE_SEL: rdata[WIDTH-1:0] = edge_q;
      REG_DB_LIMIT: rdata[DB_W-1:0]  = limit_q;
      default: ;
    endcase
    readdata_d = rd_en ? rdata : readdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= '0;
      dir_q       <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
      edge_q      <= '0;
      limit_q     <= DB_W'(DB_DEFAULT);
      readdata_q  <= '0;
      irq_q       <= 1'b0;
      prime_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      edge_q     <= edge_d;
      limit_q    <= limit_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      if (prime) prime_cnt_q <= prime_cnt_q + 3'd1;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
  assign pio_out  = data_q;
  assign pio_oe   = dir_q;

endmodule

// File: tb/tb_gpio_pio_irq.sv
// Directed bench for gpio_pio_irq: bus reads are checked by a scoreboard monitor,
// pin-level timing (irq, pio_oe, pio_out) is checked inline.
module tb_gpio_pio_irq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             chipselect = 1'b0;
  logic [2:0]       address = '0;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic             irq;
  logic [WIDTH-1:0] pio_in = '0;
  logic [WIDTH-1:0] pio_out;
  logic [WIDTH-1:0] pio_oe;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  gpio_pio_irq #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2),
    .DB_W       (16),
    .DB_DEFAULT (50000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .pio_in    (pio_in),
    .pio_out   (pio_out),
    .pio_oe    (pio_oe)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: a read accepted on a rising edge presents readdata by the next falling edge.
  always begin
    @(posedge clk);
    if (!reset && chipselect && read) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got 0x%08h with empty scoreboard", readdata);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk(e.name, readdata, e.exp);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    sb_q.push_back('{nm, exp});
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    wait_n(3);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_pio_oe", {24'h0, pio_oe}, 32'h0);
    chk("rst_pio_out", {24'h0, pio_out}, 32'h0);
    reset = 1'b0;
    wait_n(6);
    rd(3'd0, 32'h0, "rst_DATA");
    rd(3'd1, 32'h0, "rst_DIR");
    rd(3'd2, 32'h0, "rst_MASK");
    rd(3'd3, 32'h0, "rst_CAP");
    rd(3'd4, 32'h0, "rst_EDGE_SEL");
    rd(3'd5, 32'd50000, "rst_DB_LIMIT");
    rd(3'd6, 32'h0, "rst_reg6");
    rd(3'd7, 32'h0, "rst_reg7");

    // direction, output data, DATA readback mix; DB_LIMIT=0 behaves as 1
    wr(3'd5, 32'h0);
    rd(3'd5, 32'h0, "dblimit_zero_rd");
    wr(3'd1, 32'hFFFF_FF0F);
    wr(3'd0, 32'h0000_00A5);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h0, "reg6_write_ignored");
    rd(3'd1, 32'h0F, "dir_upper_ignored");
    chk("pio_oe", {24'h0, pio_oe}, 32'h0F);
    chk("pio_out", {24'h0, pio_out}, 32'hA5);
    pio_in = 8'hF0;
    wait_n(6);
    rd(3'd0, 32'hF5, "data_mix");
    rd(3'd3, 32'hF0, "cap_rise_inputs");
    wr(3'd3, 32'hFF);
    rd(3'd3, 32'h0, "cap_w1c");
    chk("irq_unmasked", {31'h0, irq}, 32'h0);

    // debounce latency with DB_LIMIT=4 on bit 4: CAP at edge 6, irq at edge 7
    pio_in = 8'h00;
    wait_n(6);
    rd(3'd3, 32'h0, "cap_fall_ignored");
    wr(3'd5, 32'd4);
    wr(3'd2, 32'h10);
    rd(3'd2, 32'h10, "mask_rd");
    pio_in = 8'h10;
    wait_n(5);
    chk("irq_edge5", {31'h0, irq}, 32'h0);
    rd(3'd3, 32'h0, "cap_before_edge6");
    chk("irq_edge6", {31'h0, irq}, 32'h0);
    rd(3'd3, 32'h10, "cap_after_edge6");
    chk("irq_edge7", {31'h0, irq}, 32'h1);

    // 3-cycle glitch on bit 5 is filtered
    pio_in = 8'h30;
    wait_n(3);
    pio_in = 8'h10;
    wait_n(10);
    rd(3'd3, 32'h10, "glitch_filtered");
    wr(3'd3, 32'h10);
    chk("irq_hold_after_clr", {31'h0, irq}, 32'h1);
    wait_n(1);
    chk("irq_fall", {31'h0, irq}, 32'h0);
    rd(3'd3, 32'h0, "cap4_cleared");

    // falling-edge select on bit 2; set beats a same-cycle clear
    wr(3'd1, 32'h0);
    wr(3'd4, 32'h04);
    rd(3'd4, 32'h04, "edge_sel_rd");
    pio_in = 8'h14;
    wait_n(12);
    rd(3'd3, 32'h0, "rise_not_captured");
    pio_in = 8'h10;
    wait_n(12);
    rd(3'd3, 32'h04, "fall_captured");
    pio_in = 8'h14;
    wait_n(12);
    wr(3'd3, 32'hFF);
    rd(3'd3, 32'h0, "cap_clear_all");
    pio_in = 8'h10;
    wait_n(5);
    wr(3'd3, 32'h04);
    rd(3'd3, 32'h04, "set_beats_clear");
    wr(3'd3, 32'h04);
    rd(3'd3, 32'h0, "cap2_cleared");

    // reset mid-debounce with irq asserted, pads idling high through release
    wr(3'd4, 32'h0);
    wr(3'd2, 32'hFF);
    wr(3'd1, 32'h01);
    pio_in = 8'h18;
    wait_n(10);
    chk("irq_before_reset", {31'h0, irq}, 32'h1);
    chk("pio_oe_before_reset", {24'h0, pio_oe}, 32'h01);
    pio_in = 8'h58;
    wait_n(3);
    #2 reset = 1'b1;
    #1;
    chk("async_irq", {31'h0, irq}, 32'h0);
    chk("async_pio_oe", {24'h0, pio_oe}, 32'h0);
    chk("async_pio_out", {24'h0, pio_out}, 32'h0);
    chk("async_readdata", readdata, 32'h0);
    pio_in = 8'hFF;
    wait_n(3);
    reset = 1'b0;
    wait_n(8);
    rd(3'd3, 32'h0, "prime_no_capture");
    rd(3'd5, 32'd50000, "dblimit_after_reset");
    rd(3'd0, 32'hFF, "prime_stable");
    chk("irq_after_reset", {31'h0, irq}, 32'h0);

    wait_n(2);
    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
